aes_mem_loader: RTL and testbench

//   Upstream feeder for the AES memory input region. Accepts a byte stream
//   (valid/ready), packs bytes little-endian into 32-bit words, and drives the

---
 rtl/aes_mem_loader.sv | 154 +++++++++++++++
 tb/tb_aes_mem_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mem_loader.sv
// aes_mem_loader: packs a valid/ready byte stream little-endian into 32-bit
// memory words, zero-pads the final partial word and appends a terminator word.
module aes_mem_loader #(
  parameter logic [9:0]  BASE_ADDR  = 10'd0,
  parameter int          MAX_WORDS  = 256,
  parameter logic [31:0] TERMINATOR = 32'hDEADBEEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_last_in,
  output logic        byte_ready_out,
  output logic [9:0]  aes_mem_wr_addr_out,
  output logic [31:0] aes_mem_data_out,
  output logic [3:0]  aes_mem_we_out,
  output logic [10:0] byte_count_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        trunc_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD  = 3'd2,
    TERM = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [9:0] LAST_WORD = 10'(MAX_WORDS - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  lane;       // next byte lane within the current word
  logic [9:0]  word;       // word offset from BASE_ADDR of the current word
  logic        handshake;
  logic        at_cap;     // current byte is the last one that fits the region

  assign byte_ready_out = (state == LOAD);
  assign busy_out       = (state == LOAD) || (state == PAD) || (state == TERM);
  assign handshake      = byte_ready_out && byte_valid_in;
  assign at_cap         = (word == LAST_WORD) && (lane == 2'd3);

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: a last byte on a partial word detours through PAD;
  // filling the region without a last byte jumps straight to TERM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start_in) begin
          state_next = LOAD;
        end else begin
          state_next = state;
        end
      end
      LOAD: begin
        if (handshake) begin
          if (byte_last_in) begin
            state_next = (lane == 2'd3) ? TERM : PAD;
          end else if (at_cap) begin
            state_next = TERM;
          end else begin
            state_next = LOAD;
          end
        end else begin
          state_next = LOAD;
        end
      end
      PAD:     state_next = TERM;
      TERM:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: registered memory write port, lane/word counters and status flags.
  // Write enable defaults to 0 each cycle; address and data hold between writes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lane                <= 2'd0;
      word                <= 10'd0;
      byte_count_out      <= 11'd0;
      aes_mem_wr_addr_out <= 10'd0;
      aes_mem_data_out    <= 32'd0;
      aes_mem_we_out      <= 4'd0;
      done_out            <= 1'b0;
      trunc_out           <= 1'b0;
    end else begin
      aes_mem_we_out <= 4'd0;
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            lane           <= 2'd0;
            word           <= 10'd0;
            byte_count_out <= 11'd0;
            done_out       <= 1'b0;
            trunc_out      <= 1'b0;
          end else if (state == DONE) begin
            done_out <= 1'b1;
          end else begin
            done_out <= done_out;
          end
        end
        LOAD: begin
          if (handshake) begin
            aes_mem_wr_addr_out <= BASE_ADDR + word;
            aes_mem_data_out    <= {4{byte_in}};
            aes_mem_we_out      <= 4'b0001 << lane;
            lane                <= lane + 2'd1;
            byte_count_out      <= byte_count_out + 11'd1;
            if (lane == 2'd3) begin
              word <= word + 10'd1;
            end else begin
              word <= word;
            end
            if (at_cap && !byte_last_in) begin
              trunc_out <= 1'b1;
            end else begin
              trunc_out <= trunc_out;
            end
          end else begin
            lane <= lane;
          end
        end
        PAD: begin
          // lane already points one past the last written byte lane
          aes_mem_wr_addr_out <= BASE_ADDR + word;
          aes_mem_data_out    <= 32'd0;
          aes_mem_we_out      <= 4'b1111 << lane;
          word                <= word + 10'd1;
        end
        TERM: begin
          aes_mem_wr_addr_out <= BASE_ADDR + word;
          aes_mem_data_out    <= TERMINATOR;
          aes_mem_we_out      <= 4'b1111;
        end
        default: begin
          aes_mem_we_out <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mem_loader.sv
// Directed self-checking bench for aes_mem_loader.
module tb_aes_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        valid;
  logic [7:0]  bdata;
  logic        last;

  logic        ready,  ready2;
  logic [9:0]  addr,   addr2;
  logic [31:0] data,   data2;
  logic [3:0]  we,     we2;
  logic [10:0] count,  count2;
  logic        busy,   busy2;
  logic        done,   done2;
  logic        trunc,  trunc2;

  int tests = 0;
  int fails = 0;

  aes_mem_loader dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start),
    .byte_valid_in(valid), .byte_in(bdata), .byte_last_in(last),
    .byte_ready_out(ready), .aes_mem_wr_addr_out(addr),
    .aes_mem_data_out(data), .aes_mem_we_out(we),
    .byte_count_out(count), .busy_out(busy), .done_out(done), .trunc_out(trunc)
  );

  aes_mem_loader #(.BASE_ADDR(10'd257)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .start_in(start),
    .byte_valid_in(valid), .byte_in(bdata), .byte_last_in(last),
    .byte_ready_out(ready2), .aes_mem_wr_addr_out(addr2),
    .aes_mem_data_out(data2), .aes_mem_we_out(we2),
    .byte_count_out(count2), .busy_out(busy2), .done_out(done2), .trunc_out(trunc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; bdata = 8'd0; last = 1'b0;
    tick(); tick();
    tests++;
    if ({ready, addr, data, we, count, busy, done, trunc} !== 60'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b addr=%0d data=%h we=%b cnt=%0d busy=%b done=%b trunc=%b, want all 0",
               ready, addr, data, we, count, busy, done, trunc);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b ready=%b, want 0 0", busy, ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b;
    int bad = 0;
    do_start();
    tests++;
    if (ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_load_entry: got ready=%b busy=%b, want 1 1", ready, busy);
    end
    for (int i = 0; i < 5; i++) begin
      b = 8'h41 + 8'(i);
      valid = 1'b1; bdata = b; last = (i == 4);
      tick();
      if (we !== (4'b0001 << (i % 4)) || addr !== 10'(i / 4) || data !== {b, b, b, b} ||
          count !== 11'(i + 1)) begin
        bad++;
        $display("FAIL basic_byte%0d: got addr=%0d we=%b data=%h cnt=%0d", i, addr, we, data, count);
      end
    end
    valid = 1'b0; last = 1'b0;
    tests++;
    if (bad != 0) fails++;
    tick();
    tests++;
    if (addr !== 10'd1 || we !== 4'b1110 || data !== 32'd0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_pad: got addr=%0d we=%b data=%h ready=%b, want 1 1110 0 0", addr, we, data, ready);
    end
    tick();
    tests++;
    if (addr !== 10'd2 || we !== 4'hF || data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_term: got addr=%0d we=%b data=%h, want 2 1111 deadbeef", addr, we, data);
    end
    tick();
    tests++;
    if (done !== 1'b1 || we !== 4'd0 || count !== 11'd5 || busy !== 1'b0 || trunc !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: got done=%b we=%b cnt=%0d busy=%b trunc=%b, want 1 0 5 0 0",
               done, we, count, busy, trunc);
    end
  endtask

  task automatic test_full_word();
    do_start();
    tests++;
    if (count !== 11'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL restart_clear: got cnt=%0d done=%b, want 0 0", count, done);
    end
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; bdata = 8'(i + 1); last = (i == 3);
      tick();
    end
    valid = 1'b0; last = 1'b0;
    tests++;
    if (we !== 4'b1000 || addr !== 10'd0 || data !== 32'h04040404) begin
      fails++;
      $display("FAIL full_last_byte: got addr=%0d we=%b data=%h, want 0 1000 04040404", addr, we, data);
    end
    tick();
    tests++;
    if (addr !== 10'd1 || we !== 4'hF || data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL full_term_no_pad: got addr=%0d we=%b data=%h, want 1 1111 deadbeef", addr, we, data);
    end
    tick();
    tests++;
    if (done !== 1'b1 || count !== 11'd4) begin
      fails++;
      $display("FAIL full_done: got done=%b cnt=%0d, want 1 4", done, count);
    end
  endtask

  task automatic test_capacity(input logic with_last);
    int bad = 0;
    do_start();
    for (int i = 0; i < 1024; i++) begin
      valid = 1'b1; bdata = 8'(i); last = with_last && (i == 1023);
      if (ready !== 1'b1) bad++;
      tick();
      if (we !== (4'b0001 << (i % 4)) || addr !== 10'(i / 4)) bad++;
    end
    last = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL cap_seq_last%0b: got %0d bad cycles, want 0", with_last, bad);
    end
    tests++;
    if (ready !== 1'b0 || count !== 11'd1024 || trunc !== ~with_last || data !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL cap_end_last%0b: got ready=%b cnt=%0d trunc=%b data=%h, want 0 1024 %b ffffffff",
               with_last, ready, count, trunc, data, ~with_last);
    end
    tick();
    tests++;
    if (addr !== 10'd256 || we !== 4'hF || data !== 32'hDEADBEEF || count !== 11'd1024 ||
        addr2 !== 10'd513) begin
      fails++;
      $display("FAIL cap_term_last%0b: got addr=%0d we=%b data=%h cnt=%0d addr_b=%0d, want 256 1111 deadbeef 1024 513",
               with_last, addr, we, data, count, addr2);
    end
    valid = 1'b0;
    tick();
    tests++;
    if (done !== 1'b1 || trunc !== ~with_last) begin
      fails++;
      $display("FAIL cap_done_last%0b: got done=%b trunc=%b, want 1 %b", with_last, done, trunc, ~with_last);
    end
  endtask

  task automatic test_valid_gaps();
    do_start();
    valid = 1'b1; bdata = 8'hA1; last = 1'b0;
    tick();
    tests++;
    if (we !== 4'b0001 || addr !== 10'd0 || data !== 32'hA1A1A1A1) begin
      fails++;
      $display("FAIL gap_first: got addr=%0d we=%b data=%h, want 0 0001 a1a1a1a1", addr, we, data);
    end
    valid = 1'b0; start = 1'b1; bdata = 8'hEE;
    tick();
    start = 1'b0;
    tests++;
    if (we !== 4'd0 || count !== 11'd1 || data !== 32'hA1A1A1A1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL gap_idle_start: got we=%b cnt=%0d data=%h busy=%b, want 0 1 a1a1a1a1 1", we, count, data, busy);
    end
    valid = 1'b1; bdata = 8'hB2;
    tick();
    tests++;
    if (we !== 4'b0010 || addr !== 10'd0 || data !== 32'hB2B2B2B2 || count !== 11'd2) begin
      fails++;
      $display("FAIL gap_second: got addr=%0d we=%b data=%h cnt=%0d, want 0 0010 b2b2b2b2 2", addr, we, data, count);
    end
    valid = 1'b0;
    tick();
    valid = 1'b1; bdata = 8'hC3; last = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0;
    tests++;
    if (we !== 4'b0100 || count !== 11'd3) begin
      fails++;
      $display("FAIL gap_third: got we=%b cnt=%0d, want 0100 3", we, count);
    end
    tick();
    tests++;
    if (we !== 4'b1000 || addr !== 10'd0 || data !== 32'd0) begin
      fails++;
      $display("FAIL gap_pad: got addr=%0d we=%b data=%h, want 0 1000 0", addr, we, data);
    end
    tick();
    tests++;
    if (addr !== 10'd1 || data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL gap_term: got addr=%0d data=%h, want 1 deadbeef", addr, data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; bdata = 8'(8'h10 + i); last = 1'b0;
      tick();
    end
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ready, addr, data, we, count, busy, done, trunc} !== 60'd0) begin
      fails++;
      $display("FAIL mid_reset: got ready=%b addr=%0d data=%h we=%b cnt=%0d busy=%b, want all 0",
               ready, addr, data, we, count, busy);
    end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_base_addr();
    do_start();
    valid = 1'b1; bdata = 8'h77; last = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0;
    tests++;
    if (addr2 !== 10'd257 || we2 !== 4'b0001 || addr !== 10'd0 || we !== 4'b0001 || count !== 11'd1) begin
      fails++;
      $display("FAIL base_write: got addr_b=%0d we_b=%b addr=%0d we=%b cnt=%0d, want 257 0001 0 0001 1",
               addr2, we2, addr, we, count);
    end
    tick();
    tests++;
    if (addr2 !== 10'd257 || we2 !== 4'b1110 || data2 !== 32'd0) begin
      fails++;
      $display("FAIL base_pad: got addr_b=%0d we_b=%b data_b=%h, want 257 1110 0", addr2, we2, data2);
    end
    tick();
    tests++;
    if (addr2 !== 10'd258 || we2 !== 4'hF || data2 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL base_term: got addr_b=%0d we_b=%b data_b=%h, want 258 1111 deadbeef", addr2, we2, data2);
    end
    tick();
    tests++;
    if (done2 !== 1'b1 || count2 !== 11'd1) begin
      fails++;
      $display("FAIL base_done: got done_b=%b cnt_b=%0d, want 1 1", done2, count2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_word();
    test_capacity(1'b0);
    test_capacity(1'b1);
    test_valid_gaps();
    test_reset_mid();
    test_base_addr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
